// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the data-memory responder: bus widths, MMIO register
// map, STATUS bit positions, address-region type and the byte-lane merge helper.
package data_ram_ctrl_pkg;

    // Bus widths seen by the MEM stage
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int STRB_W     = 4;

    // The MMIO window is 4 KiB, so the low 12 address bits select a register
    localparam int MMIO_OFS_W = 12;

    // Byte offsets of the registers inside the MMIO window
    localparam logic [MMIO_OFS_W-1:0] OFS_GPIO    = 12'h000;
    localparam logic [MMIO_OFS_W-1:0] OFS_COUNT   = 12'h004;
    localparam logic [MMIO_OFS_W-1:0] OFS_COMPARE = 12'h008;
    localparam logic [MMIO_OFS_W-1:0] OFS_STATUS  = 12'h00C;

    // STATUS register bit positions (also the write-1-to-clear positions)
    localparam int STATUS_IRQ_BIT = 0;
    localparam int STATUS_ERR_BIT = 1;

    // Where a request lands after address decode
    typedef enum logic [1:0] {
        REGION_RAM     = 2'd0,
        REGION_MMIO    = 2'd1,
        REGION_ILLEGAL = 2'd2
    } region_e;

    // Replace only the byte lanes whose strobe is set; the requester has
    // already placed each byte on its own lane.
    function automatic logic [DATA_W-1:0] apply_strobe(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strobe
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int lane = 0; lane < STRB_W; lane++) begin
            if (strobe[lane]) begin
                merged[8*lane +: 8] = new_word[8*lane +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_mmio_regs.sv
// Memory-mapped register block of the data-memory port: GPIO output register,
// free-running cycle counter, compare register, sticky timer/bus-error flags
// and the combinational read mux the top level registers into read data.
module data_ram_ctrl_mmio_regs
    import data_ram_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [STRB_W-1:0]         i_write_en,
    input  logic [MMIO_OFS_W-1:2]     i_word_ofs,
    input  logic [DATA_W-1:0]         i_write_data,
    input  logic                      i_err_set,
    output logic                      o_ofs_ok,
    output logic [DATA_W-1:0]         o_read_data,
    output logic [DATA_W-1:0]         o_gpio,
    output logic                      o_timer_irq,
    output logic                      o_bus_error
);

    logic [DATA_W-1:0]     r_gpio;
    logic [DATA_W-1:0]     r_count;
    logic [DATA_W-1:0]     r_compare;
    logic                  r_timer_irq;
    logic                  r_bus_error;

    logic [MMIO_OFS_W-1:0] w_byte_ofs;
    logic                  w_hit_gpio;
    logic                  w_hit_count;
    logic                  w_hit_compare;
    logic                  w_hit_status;
    logic                  w_write;
    logic                  w_wr_gpio;
    logic                  w_wr_compare;
    logic                  w_wr_status;
    logic                  w_match;
    logic                  w_irq_clr;
    logic                  w_err_clr;

    // Address bits [1:0] never reach this block, so rebuild an aligned offset
    assign w_byte_ofs    = {i_word_ofs, 2'b00};
    assign w_hit_gpio    = (w_byte_ofs == OFS_GPIO);
    assign w_hit_count   = (w_byte_ofs == OFS_COUNT);
    assign w_hit_compare = (w_byte_ofs == OFS_COMPARE);
    assign w_hit_status  = (w_byte_ofs == OFS_STATUS);
    assign o_ofs_ok      = w_hit_gpio | w_hit_count | w_hit_compare | w_hit_status;

    // A request with no strobes is a read; COUNT has no write path at all
    assign w_write       = i_req && (i_write_en != '0);
    assign w_wr_gpio     = w_write && w_hit_gpio;
    assign w_wr_compare  = w_write && w_hit_compare;
    assign w_wr_status   = w_write && w_hit_status;

    // A COMPARE of zero disables the timer so the counter's reset value
    // cannot raise a spurious interrupt
    assign w_match       = (r_count == r_compare) && (r_compare != '0);

    // STATUS clears only honour lane 0, where both flag bits live
    assign w_irq_clr     = w_wr_status && i_write_en[0] && i_write_data[STATUS_IRQ_BIT];
    assign w_err_clr     = w_wr_status && i_write_en[0] && i_write_data[STATUS_ERR_BIT];

    // GPIO output register, byte-strobed writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio <= '0;
        end else if (w_wr_gpio) begin
            r_gpio <= apply_strobe(r_gpio, i_write_data, i_write_en);
        end
    end

    // Free-running cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

    // Compare register, byte-strobed writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_compare <= '0;
        end else if (w_wr_compare) begin
            r_compare <= apply_strobe(r_compare, i_write_data, i_write_en);
        end
    end

    // Sticky timer flag; a match in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer_irq <= 1'b0;
        end else if (w_match) begin
            r_timer_irq <= 1'b1;
        end else if (w_irq_clr) begin
            r_timer_irq <= 1'b0;
        end
    end

    // Sticky bus-error flag; a new illegal access outranks a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_error <= 1'b0;
        end else if (i_err_set) begin
            r_bus_error <= 1'b1;
        end else if (w_err_clr) begin
            r_bus_error <= 1'b0;
        end
    end

    // Read mux: COUNT and STATUS return their values before this edge updates them
    always_comb begin
        o_read_data = '0;
        if (w_hit_gpio) begin
            o_read_data = r_gpio;
        end else if (w_hit_count) begin
            o_read_data = r_count;
        end else if (w_hit_compare) begin
            o_read_data = r_compare;
        end else if (w_hit_status) begin
            o_read_data[STATUS_IRQ_BIT] = r_timer_irq;
            o_read_data[STATUS_ERR_BIT] = r_bus_error;
        end
    end

    assign o_gpio      = r_gpio;
    assign o_timer_irq = r_timer_irq;
    assign o_bus_error = r_bus_error;

endmodule

// File: rtl/data_ram_ctrl.sv
// Responder for the pipeline's data-memory port. Decodes each single-cycle
// request into RAM, MMIO register window or illegal space, owns the data RAM
// array and registers read data for the WB stage one clock later.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int                ADDR_WIDTH = 12,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 32'h1FFF_F000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en,
    input  logic [STRB_W-1:0] ram_write_en,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_write_data,
    output logic [DATA_W-1:0] ram_read_data,
    output logic [DATA_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              bus_error
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_W-1:0]     r_mem [RAM_DEPTH];
    logic [DATA_W-1:0]     r_read_data;

    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_ram_hit;
    logic                  w_mmio_hit;
    logic                  w_mmio_ofs_ok;
    logic                  w_mmio_req;
    logic                  w_is_write;
    logic                  w_err_set;
    logic [DATA_W-1:0]     w_mmio_rdata;
    region_e               w_region;
    logic                  w_unused;

    // Requests are word aligned; the byte-offset bits carry no meaning here
    assign w_unused   = &{1'b0, ram_addr[1:0]};

    assign w_word_idx = ram_addr[ADDR_WIDTH+1:2];
    assign w_ram_hit  = (ram_addr[ADDR_W-1:ADDR_WIDTH+2] == '0);
    assign w_mmio_hit = (ram_addr[ADDR_W-1:MMIO_OFS_W] == MMIO_BASE[ADDR_W-1:MMIO_OFS_W]);
    assign w_is_write = (ram_write_en != '0);

    // Classify the request; unknown offsets inside the MMIO window are illegal too
    always_comb begin
        w_region = REGION_ILLEGAL;
        if (w_ram_hit) begin
            w_region = REGION_RAM;
        end else if (w_mmio_hit && w_mmio_ofs_ok) begin
            w_region = REGION_MMIO;
        end
    end

    assign w_mmio_req = ram_en && w_mmio_hit && !w_ram_hit;
    assign w_err_set  = ram_en && (w_region == REGION_ILLEGAL);

    data_ram_ctrl_mmio_regs u_mmio (
        .clk          (clk),
        .rst          (rst),
        .i_req        (w_mmio_req),
        .i_write_en   (ram_write_en),
        .i_word_ofs   (ram_addr[MMIO_OFS_W-1:2]),
        .i_write_data (ram_write_data),
        .i_err_set    (w_err_set),
        .o_ofs_ok     (w_mmio_ofs_ok),
        .o_read_data  (w_mmio_rdata),
        .o_gpio       (gpio_out),
        .o_timer_irq  (timer_irq),
        .o_bus_error  (bus_error)
    );

    // RAM byte-lane writes; contents survive reset but reset blocks new writes
    always_ff @(posedge clk) begin
        if (!rst && ram_en && w_is_write && (w_region == REGION_RAM)) begin
            r_mem[w_word_idx] <= apply_strobe(r_mem[w_word_idx], ram_write_data, ram_write_en);
        end
    end

    // Read-data register: loads only on reads, holds across writes and idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data <= '0;
        end else if (ram_en && !w_is_write) begin
            case (w_region)
                REGION_RAM:  r_read_data <= r_mem[w_word_idx];
                REGION_MMIO: r_read_data <= w_mmio_rdata;
                default:     r_read_data <= '0;
            endcase
        end
    end

    assign ram_read_data = r_read_data;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Testbench for data_ram_ctrl: directed walk through the memory map and timer
// behaviour followed by randomized traffic, all checked against a cycle-level
// behavioural model of the memory port kept inside this module.
module tb_data_ram_ctrl;

    localparam logic [31:0] MMIO_BASE = 32'h1FFF_F000;
    localparam int          RAM_WORDS = 4096;
    localparam logic [31:0] RAM_BYTES = 32'd16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        ramEn;
    logic [3:0]  ramWriteEn;
    logic [31:0] ramAddr;
    logic [31:0] ramWriteData;
    logic [31:0] ramReadData;
    logic [31:0] gpioOut;
    logic        timerIrq;
    logic        busError;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state
    logic [31:0] mMem [RAM_WORDS];
    bit          mKnown [RAM_WORDS];
    logic [31:0] mCount;
    logic [31:0] mCompare;
    logic [31:0] mGpio;
    logic [31:0] mRead;
    bit          mReadKnown = 1'b0;
    bit          mIrq;
    bit          mErr;

    logic [31:0] cmpTarget;
    logic [31:0] randAddr;
    logic [31:0] randData;
    logic [3:0]  randStrb;
    bit          randEn;
    bit          randRst;

    data_ram_ctrl #(
        .ADDR_WIDTH (12),
        .MMIO_BASE  (32'h1FFF_F000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ramEn),
        .ram_write_en   (ramWriteEn),
        .ram_addr       (ramAddr),
        .ram_write_data (ramWriteData),
        .ram_read_data  (ramReadData),
        .gpio_out       (gpioOut),
        .timer_irq      (timerIrq),
        .bus_error      (busError)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord, input logic [31:0] newWord,
                                               input logic [3:0] strb);
        logic [31:0] res;
        res = oldWord;
        for (int lane = 0; lane < 4; lane++) begin
            if (strb[lane]) res[8*lane +: 8] = newWord[8*lane +: 8];
        end
        return res;
    endfunction

    // Drive one request for one clock, advance the model by that edge, then compare
    task automatic applyStimulus(input bit doReset, input bit en, input logic [3:0] we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bit          irqSet;
        bit          irqClr;
        bit          errSet;
        bit          errClr;
        bit          isRead;
        int          word;
        logic [31:0] ofs;
        @(negedge clk);
        rst          = doReset;
        ramEn        = en;
        ramWriteEn   = we;
        ramAddr      = addr;
        ramWriteData = wdata;
        @(posedge clk);
        if (doReset) begin
            mRead      = 32'd0;
            mReadKnown = 1'b1;
            mGpio      = 32'd0;
            mCount     = 32'd0;
            mCompare   = 32'd0;
            mIrq       = 1'b0;
            mErr       = 1'b0;
        end else begin
            irqSet = (mCount == mCompare) && (mCompare != 32'd0);
            irqClr = 1'b0;
            errSet = 1'b0;
            errClr = 1'b0;
            isRead = (we == 4'd0);
            if (en) begin
                if (addr < RAM_BYTES) begin
                    word = int'(addr / 32'd4);
                    if (isRead) begin
                        mRead      = mMem[word];
                        mReadKnown = mKnown[word];
                    end else begin
                        mMem[word]   = mergeLanes(mMem[word], wdata, we);
                        mKnown[word] = mKnown[word] || (we == 4'hF);
                    end
                end else if (addr >= MMIO_BASE && addr < MMIO_BASE + 32'd4096) begin
                    ofs = (addr - MMIO_BASE) & ~32'd3;
                    case (ofs)
                        32'd0: begin
                            if (isRead) begin mRead = mGpio; mReadKnown = 1'b1; end
                            else mGpio = mergeLanes(mGpio, wdata, we);
                        end
                        32'd4: begin
                            if (isRead) begin mRead = mCount; mReadKnown = 1'b1; end
                        end
                        32'd8: begin
                            if (isRead) begin mRead = mCompare; mReadKnown = 1'b1; end
                            else mCompare = mergeLanes(mCompare, wdata, we);
                        end
                        32'd12: begin
                            if (isRead) begin
                                mRead      = {30'd0, mErr, mIrq};
                                mReadKnown = 1'b1;
                            end else if (we[0]) begin
                                irqClr = wdata[0];
                                errClr = wdata[1];
                            end
                        end
                        default: begin
                            errSet = 1'b1;
                            if (isRead) begin mRead = 32'd0; mReadKnown = 1'b1; end
                        end
                    endcase
                end else begin
                    errSet = 1'b1;
                    if (isRead) begin mRead = 32'd0; mReadKnown = 1'b1; end
                end
            end
            mCount = mCount + 32'd1;
            mIrq   = irqSet ? 1'b1 : (irqClr ? 1'b0 : mIrq);
            mErr   = errSet ? 1'b1 : (errClr ? 1'b0 : mErr);
        end
        #1;
        if (mReadKnown) checkOutput("rdata", ramReadData, mRead);
        checkOutput("gpio", gpioOut, mGpio);
        checkOutput("timerIrq", {31'd0, timerIrq}, {31'd0, mIrq});
        checkOutput("busError", {31'd0, busError}, {31'd0, mErr});
    endtask

    initial begin
        rst          = 1'b1;
        ramEn        = 1'b0;
        ramWriteEn   = 4'd0;
        ramAddr      = 32'd0;
        ramWriteData = 32'd0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
        checkOutput("rstRdata", ramReadData, 32'd0);
        checkOutput("rstGpio", gpioOut, 32'd0);
        checkOutput("rstFlags", {30'd0, busError, timerIrq}, 32'd0);

        // RAM full write, read, partial lane write, merged read
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        checkOutput("rdHoldAfterRst", ramReadData, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h10, 32'd0);
        checkOutput("rdFull", ramReadData, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 4'b0010, 32'h10, 32'h0000_5500);
        checkOutput("rdHoldOnWrite", ramReadData, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h13, 32'd0);
        checkOutput("rdMerged", ramReadData, 32'hDEAD_55EF);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h20, 32'd0);
        checkOutput("rdHoldIdle", ramReadData, 32'hDEAD_55EF);

        // COUNT after reset, then a write to COUNT is ignored without error
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'h4, 32'd0);
        checkOutput("count5", ramReadData, 32'd5);
        applyStimulus(1'b0, 1'b1, 4'hF, MMIO_BASE + 32'h4, 32'h1234_0000);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'h4, 32'd0);
        checkOutput("countWriteIgnored", ramReadData, 32'd7);
        checkOutput("countWriteNoErr", {31'd0, busError}, 32'd0);

        // Preload COUNT close to the wrap point and watch it roll over
        force dut.u_mmio.r_count = 32'hFFFF_FFFD;
        #1;
        release dut.u_mmio.r_count;
        mCount = 32'hFFFF_FFFD;
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'h4, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'h4, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'h4, 32'd0);
        checkOutput("countMax", ramReadData, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'h4, 32'd0);
        checkOutput("countWrap", ramReadData, 32'd0);

        // GPIO upper-lane write and readback
        applyStimulus(1'b0, 1'b1, 4'b1100, MMIO_BASE, 32'h1234_5678);
        checkOutput("gpioStrobe", gpioOut, 32'h1234_0000);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE, 32'd0);
        checkOutput("gpioRead", ramReadData, 32'h1234_0000);

        // Illegal accesses and bus-error clear
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h2000_0000, 32'd0);
        checkOutput("illegalRdZero", ramReadData, 32'd0);
        checkOutput("illegalErr", {31'd0, busError}, 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h1, MMIO_BASE + 32'hC, 32'h2);
        checkOutput("errCleared", {31'd0, busError}, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'h10, 32'd0);
        checkOutput("badOfsErr", {31'd0, busError}, 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h0, MMIO_BASE + 32'hC, 32'd0);
        checkOutput("statusRead", ramReadData, 32'd2);
        applyStimulus(1'b0, 1'b1, 4'h1, MMIO_BASE + 32'hC, 32'h2);

        // Reset in the middle of traffic, with a competing GPIO write
        applyStimulus(1'b1, 1'b1, 4'hF, MMIO_BASE, 32'hFFFF_FFFF);
        checkOutput("midRstGpio", gpioOut, 32'd0);
        checkOutput("midRstRdata", ramReadData, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h10, 32'd0);
        checkOutput("ramRetained", ramReadData, 32'hDEAD_55EF);

        // Timer compare at 20
        applyStimulus(1'b0, 1'b1, 4'hF, MMIO_BASE + 32'h8, 32'd20);
        for (int k = 0; k < 40 && mCount != 32'd20; k++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("irqBeforeMatch", {31'd0, timerIrq}, 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("irqRise", {31'd0, timerIrq}, 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h1, MMIO_BASE + 32'hC, 32'h1);
        checkOutput("irqClear", {31'd0, timerIrq}, 32'd0);

        // A clear landing on a fresh match loses to the set
        cmpTarget = mCount + 32'd6;
        applyStimulus(1'b0, 1'b1, 4'hF, MMIO_BASE + 32'h8, cmpTarget);
        for (int k = 0; k < 20 && mCount != cmpTarget; k++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h1, MMIO_BASE + 32'hC, 32'h1);
        checkOutput("irqSetWins", {31'd0, timerIrq}, 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h1, MMIO_BASE + 32'hC, 32'h1);
        checkOutput("irqPlainClear", {31'd0, timerIrq}, 32'd0);

        // Seed the RAM words used by random traffic so every read is predictable
        for (int w = 0; w < 16; w++) applyStimulus(1'b0, 1'b1, 4'hF, 32'(w * 4), $urandom);
        applyStimulus(1'b0, 1'b1, 4'hF, RAM_BYTES - 32'd4, $urandom);

        // Randomized traffic across RAM, MMIO and illegal space
        for (int n = 0; n < 600; n++) begin
            randEn   = 1'b1;
            randRst  = ($urandom_range(0, 63) == 0);
            randData = $urandom;
            randStrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    if ($urandom_range(0, 7) == 0) randAddr = RAM_BYTES - 32'd4;
                    else randAddr = 32'($urandom_range(0, 15) * 4);
                    randAddr = randAddr + 32'($urandom_range(0, 3));
                end
                4, 5, 6: begin
                    case ($urandom_range(0, 6))
                        0: randAddr = MMIO_BASE;
                        1: randAddr = MMIO_BASE + 32'h4;
                        2: randAddr = MMIO_BASE + 32'h8;
                        3: randAddr = MMIO_BASE + 32'hC;
                        4: randAddr = MMIO_BASE + 32'h10;
                        5: randAddr = MMIO_BASE + 32'hFFC;
                        default: randAddr = MMIO_BASE + 32'($urandom_range(0, 4095));
                    endcase
                    randAddr = randAddr | 32'($urandom_range(0, 3));
                end
                7: begin
                    case ($urandom_range(0, 4))
                        0: randAddr = RAM_BYTES;
                        1: randAddr = 32'h2000_0000;
                        2: randAddr = MMIO_BASE - 32'd4;
                        3: randAddr = 32'hFFFF_FFFC;
                        default: randAddr = $urandom | 32'h8000_0000;
                    endcase
                end
                8: begin
                    randAddr = MMIO_BASE + 32'h8;
                    randStrb = 4'hF;
                    randData = mCount + 32'($urandom_range(1, 8));
                end
                default: begin
                    randEn   = 1'b0;
                    randAddr = $urandom;
                end
            endcase
            applyStimulus(randRst, randEn, randStrb, randAddr, randData);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Responder side of the pipeline's data-memory port: accepts the word-aligned request (`ram_en`, byte-lane `ram_write_en`, `ram_addr`, `ram_write_data`) driven by the MEM stage and returns registered read data to the WB stage one clock later. It owns the data RAM array and a small memory-mapped register window (GPIO, free-running cycle counter, compare/interrupt, status). It sits between the MEM/WB pipeline boundary and the board-level outputs.

## Interface
- `ADDR_WIDTH`, 12: word-address bits of the RAM array (2^ADDR_WIDTH 32-bit words, byte range [0, 4·2^ADDR_WIDTH)).
- `MMIO_BASE`, 32'h1FFF_F000: byte base of the 4 KiB MMIO window; must be 4 KiB aligned and outside the RAM range.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ram_en`  in  1  request valid this cycle.
- `ram_write_en`  in  4  byte-lane write strobes; 0 with `ram_en`=1 means read.
- `ram_addr`  in  32  byte address; bits [1:0] ignored (treated as 00).
- `ram_write_data`  in  32  write data, already lane-aligned by the requester.
- `ram_read_data`  out  32  registered read data.
- `gpio_out`  out  32  GPIO register contents.
- `timer_irq`  out  1  sticky compare-match flag.
- `bus_error`  out  1  sticky illegal-access flag.

## Operation
- Decode per request: RAM if `ram_addr` < 4·2^ADDR_WIDTH; MMIO if `ram_addr[31:12]` == `MMIO_BASE[31:12]`; otherwise illegal.
- RAM write: for each lane i with `ram_write_en[i]`=1, byte i of word `ram_addr[ADDR_WIDTH+1:2]` ← `ram_write_data[8i+7:8i]`; other lanes unchanged. Any strobe pattern allowed.
- RAM read: `ram_read_data` ← addressed word.
- MMIO offsets (`ram_addr[11:0]`):
  - 0x000 GPIO: RW, byte-strobed.
  - 0x004 COUNT: RO; writes ignored, no error.
  - 0x008 COMPARE: RW, byte-strobed.
  - 0x00C STATUS: bit0 `timer_irq`, bit1 `bus_error`, rest 0; write-1-to-clear using lane 0 only.
  - any other offset: illegal.
- Illegal access: write dropped; read returns 0; `bus_error` set.
- COUNT increments by 1 every cycle, wraps 32'hFFFF_FFFF → 0.
- `timer_irq` set in any cycle where COUNT == COMPARE and COMPARE ≠ 0; held until cleared via STATUS.
- Set and W1C clear of the same flag in one cycle: set wins.

## Timing
- Reset (`rst`=1 at edge): `ram_read_data`=0, `gpio_out`=0, COUNT=0, COMPARE=0, `timer_irq`=0, `bus_error`=0. RAM contents are not reset. Reset overrides any same-cycle request.
- Read latency 1: request at edge N, data valid after edge N, stable until next read edge.
- `ram_read_data` holds its value on write cycles and idle cycles (`ram_en`=0).
- Write takes effect at the request edge; a read of the same address in the next cycle returns the new data. No same-cycle read/write, since one request per cycle.
- COUNT read returns the pre-increment register value at the sampling edge.
- `gpio_out`, `timer_irq`, `bus_error` are direct register outputs, updated at the write edge.
- No backpressure; every request completes in one cycle.

## Structure
- Shared package: data/address widths (32), strobe width (4), MMIO offsets (GPIO/COUNT/COMPARE/STATUS), STATUS bit positions.
- Sub-module `mmio_regs`: GPIO, COUNT, COMPARE, STATUS flags, and read mux. Top level keeps the RAM array, decode, and the read-data register.

## Test plan
- Write 32'hDEADBEEF, strobe 4'b1111, addr 0x10; then write 32'h0000_5500, strobe 4'b0010, same addr; then read → `ram_read_data`=32'hDEADBEEF during write cycles, 32'hDEAD55EF one cycle after the read.
- Reset, then read COUNT at cycle 5 after reset release → 5. Preload COUNT near wrap (force), then observe 32'hFFFF_FFFF → 0.
- Write COMPARE=20 → `timer_irq` rises the cycle after COUNT=20. Write STATUS=1 in the same cycle as a new match → flag stays 1. Plain clear later → 0.
- Read addr 0x2000_0000 → `ram_read_data`=0, `bus_error`=1. Write STATUS=32'h2 → `bus_error`=0. MMIO offset 0x010 read also sets it.
- Write GPIO 32'h12345678, strobe 4'b1100 → `gpio_out`=32'h12340000. Assert `rst` mid-sequence → all outputs 0 next cycle, RAM word at 0x10 retained.
